// File: rtl/alu_pkg.sv
// Shared constants for the ALU and its two-port arbiter: widths, opcodes, FSM states.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 4;

  localparam logic [SEL_W-1:0] OP_ADD  = 4'h0;
  localparam logic [SEL_W-1:0] OP_SUB  = 4'h1;
  localparam logic [SEL_W-1:0] OP_MUL  = 4'h2;
  localparam logic [SEL_W-1:0] OP_DIV  = 4'h3;
  localparam logic [SEL_W-1:0] OP_SHL  = 4'h4;
  localparam logic [SEL_W-1:0] OP_SHR  = 4'h5;
  localparam logic [SEL_W-1:0] OP_ROL  = 4'h6;
  localparam logic [SEL_W-1:0] OP_ROR  = 4'h7;
  localparam logic [SEL_W-1:0] OP_AND  = 4'h8;
  localparam logic [SEL_W-1:0] OP_OR   = 4'h9;
  localparam logic [SEL_W-1:0] OP_XOR  = 4'hA;
  localparam logic [SEL_W-1:0] OP_NOR  = 4'hB;
  localparam logic [SEL_W-1:0] OP_NAND = 4'hC;
  localparam logic [SEL_W-1:0] OP_XNOR = 4'hD;
  localparam logic [SEL_W-1:0] OP_GT   = 4'hE;
  localparam logic [SEL_W-1:0] OP_EQ   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU. CarryOut is always the carry of A+B, whatever the opcode.
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [SEL_W-1:0]  ALU_Sel,
  output logic [DATA_W-1:0] ALU_Out,
  output logic              CarryOut
);

  logic [DATA_W:0] sum_s;

  assign sum_s    = {1'b0, A} + {1'b0, B};
  assign CarryOut = sum_s[DATA_W];

  // Opcode decode; division by zero yields zero so the result is always defined
  always_comb begin
    ALU_Out = '0;
    case (ALU_Sel)
      OP_ADD:  ALU_Out = sum_s[DATA_W-1:0];
      OP_SUB:  ALU_Out = A - B;
      OP_MUL:  ALU_Out = A * B;
      OP_DIV: begin
        if (B == '0) begin
          ALU_Out = '0;
        end else begin
          ALU_Out = A / B;
        end
      end
      OP_SHL:  ALU_Out = {A[DATA_W-2:0], 1'b0};
      OP_SHR:  ALU_Out = {1'b0, A[DATA_W-1:1]};
      OP_ROL:  ALU_Out = {A[DATA_W-2:0], A[DATA_W-1]};
      OP_ROR:  ALU_Out = {A[0], A[DATA_W-1:1]};
      OP_AND:  ALU_Out = A & B;
      OP_OR:   ALU_Out = A | B;
      OP_XOR:  ALU_Out = A ^ B;
      OP_NOR:  ALU_Out = ~(A | B);
      OP_NAND: ALU_Out = ~(A & B);
      OP_XNOR: ALU_Out = ~(A ^ B);
      OP_GT:   ALU_Out = {{(DATA_W-1){1'b0}}, (A > B)};
      OP_EQ:   ALU_Out = {{(DATA_W-1){1'b0}}, (A == B)};
      default: ALU_Out = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; one operation in flight.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              id_q, id_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              gnt_valid_s, gnt_id_s, accept_s, rsp_done_s;
  logic [DATA_W-1:0] alu_out_s;
  logic              alu_carry_s;

  alu u_alu (
    .A        (a_q),
    .B        (b_q),
    .ALU_Sel  (sel_q),
    .ALU_Out  (alu_out_s),
    .CarryOut (alu_carry_s)
  );

  // Grant selection: a lone requester wins outright, a tie goes to rr_q
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_id_s    = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = rr_q;
    end else if (req0_valid) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = 1'b0;
    end else if (req1_valid) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = 1'b1;
    end else begin
      gnt_valid_s = 1'b0;
      gnt_id_s    = 1'b0;
    end
  end

  assign accept_s   = (state_q == ST_IDLE) && gnt_valid_s;
  assign rsp_done_s = (state_q == ST_RESP) && rsp_ready;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: IDLE -> EXEC on grant, EXEC -> RESP, RESP -> IDLE on consume
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid_s) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; ready is held low while reset is asserted
  always_comb begin
    req0_ready = (!reset) && accept_s && (gnt_id_s == 1'b0);
    req1_ready = (!reset) && accept_s && (gnt_id_s == 1'b1);
    rsp_valid  = (state_q == ST_RESP);
    busy       = (state_q != ST_IDLE);
  end

  // Datapath next values: operand capture on grant, result capture in EXEC, bookkeeping on consume
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    id_d     = id_q;
    result_d = result_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    if (accept_s) begin
      id_d = gnt_id_s;
      if (gnt_id_s) begin
        a_d   = req1_a;
        b_d   = req1_b;
        sel_d = req1_sel;
      end else begin
        a_d   = req0_a;
        b_d   = req0_b;
        sel_d = req0_sel;
      end
    end else begin
      id_d = id_q;
    end
    if (state_q == ST_EXEC) begin
      result_d = alu_out_s;
      carry_d  = alu_carry_s;
    end else begin
      result_d = result_q;
    end
    if (rsp_done_s) begin
      cnt_d = cnt_q + 1'b1;
      rr_d  = ~id_q;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      id_q     <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      rr_q     <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      id_q     <= id_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
    end
  end

  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_carry  = carry_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: random and directed stimulus, transaction-level reference model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int CNT_W = 4;

  logic             clk, reset;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0]       req0_a, req0_b, req1_a, req1_b;
  logic [3:0]       req0_sel, req1_sel;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_carry, busy;
  logic [7:0]       rsp_result;
  logic [CNT_W-1:0] op_count;

  alu_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .busy(busy), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       id;
    logic [7:0] res;
    logic       c;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // model state: idle flag, cycles since accept, tie-break owner, completed count
  bit   m_free = 1'b1;
  int   m_age  = 0;
  bit   m_rr   = 1'b0;
  int   m_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference ALU from the opcode table, plain integer arithmetic
  function automatic logic [8:0] ref_alu(input logic [3:0] sel, input int a, input int b);
    int   r;
    logic cy;
    case (sel)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a * b;
      4'h3: r = (b == 0) ? 0 : a / b;
      4'h4: r = a * 2;
      4'h5: r = a / 2;
      4'h6: r = a * 2 + a / 128;
      4'h7: r = a / 2 + (a % 2) * 128;
      4'h8: r = a & b;
      4'h9: r = a | b;
      4'hA: r = a ^ b;
      4'hB: r = ~(a | b);
      4'hC: r = ~(a & b);
      4'hD: r = ~(a ^ b);
      4'hE: r = (a > b) ? 1 : 0;
      default: r = (a == b) ? 1 : 0;
    endcase
    cy = ((a + b) > 255);
    return {cy, r[7:0]};
  endfunction

  // monitor: checks every output against the model each cycle and scores responses
  always @(negedge clk) begin
    bit         fr, gv, gid, exp_rsp;
    exp_t       e;
    logic [8:0] rv;
    if (reset) begin
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_op_count", 32'(op_count), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_req0_ready", 32'(req0_ready), 32'd0);
      check("rst_req1_ready", 32'(req1_ready), 32'd0);
      exp_q.delete();
      m_free = 1'b1;
      m_age  = 0;
      m_rr   = 1'b0;
      m_cnt  = 0;
    end else begin
      fr = m_free;
      if (!m_free) m_age++;
      exp_rsp = !m_free && (m_age >= 2);
      gv  = 1'b0;
      gid = 1'b0;
      if (fr) begin
        if (req0_valid && req1_valid) begin gv = 1'b1; gid = m_rr; end
        else if (req0_valid) begin gv = 1'b1; gid = 1'b0; end
        else if (req1_valid) begin gv = 1'b1; gid = 1'b1; end
      end
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
      check("busy", 32'(busy), 32'(!fr));
      check("op_count", 32'(op_count), 32'(m_cnt % 16));
      check("req0_ready", 32'(req0_ready), 32'(gv && !gid));
      check("req1_ready", 32'(req1_ready), 32'(gv && gid));
      if (exp_rsp && exp_q.size() > 0) begin
        e = exp_q[0];
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_result", 32'(rsp_result), 32'(e.res));
        check("rsp_carry", 32'(rsp_carry), 32'(e.c));
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          m_rr   = !e.id;
          m_cnt  = m_cnt + 1;
          m_free = 1'b1;
        end
      end
      if (fr && gv) begin
        if (gid) rv = ref_alu(req1_sel, int'(req1_a), int'(req1_b));
        else     rv = ref_alu(req0_sel, int'(req0_a), int'(req0_b));
        e.id  = gid;
        e.res = rv[7:0];
        e.c   = rv[8];
        exp_q.push_back(e);
        m_free = 1'b0;
        m_age  = 0;
      end
    end
  end

  task automatic rand_ops();
    req0_a   = 8'($urandom);
    req0_b   = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
    req0_sel = 4'($urandom);
    req1_a   = 8'($urandom);
    req1_b   = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
    req1_sel = 4'($urandom);
  endtask

  task automatic issue(input bit port, input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    bit got = 1'b0;
    if (port) begin req1_a = a; req1_b = b; req1_sel = sel; req1_valid = 1'b1; end
    else      begin req0_a = a; req0_b = b; req0_sel = sel; req0_valid = 1'b1; end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      got = port ? req1_ready : req0_ready;
      @(posedge clk);
      #1;
      if (got) break;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("issue_accept", 32'(got), 32'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rand_ops();
    // both requesters valid straight out of reset: grants alternate
    req0_valid = 1'b1; req1_valid = 1'b1;
    cycles(3);
    reset = 1'b0;
    repeat (14) begin cycles(1); rand_ops(); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    cycles(4);

    // single-requester directed operations
    issue(1'b0, 8'h0A, 8'h02, OP_ADD);
    cycles(4);
    issue(1'b1, 8'hF6, 8'h0A, OP_ADD);
    cycles(4);

    // consumer stall in RESP with both requesters pending
    rsp_ready = 1'b0;
    issue(1'b0, 8'h81, 8'h7F, OP_SUB);
    req0_valid = 1'b1; req1_valid = 1'b1;
    cycles(6);
    rsp_ready = 1'b1;
    cycles(1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    cycles(6);

    // reset while the operation is in EXEC: it must vanish
    issue(1'b1, 8'hFF, 8'h01, OP_ADD);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(4);

    // back-to-back stream across the counter wrap (17 operations)
    req0_valid = 1'b1;
    repeat (17 * 3) begin rand_ops(); cycles(1); end
    req0_valid = 1'b0;
    cycles(4);

    // random traffic, including requesters dropping valid before grant
    repeat (400) begin
      rand_ops();
      req0_valid = ($urandom_range(99) < 40);
      req1_valid = ($urandom_range(99) < 40);
      rsp_ready  = ($urandom_range(99) < 65);
      cycles(1);
    end

    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    cycles(10);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
